can_frame_decoder: RTL and testbench

Receive-side counterpart to the CAN bit stuffer: consumes a serial CAN 2.0A (standard, 11-bit ID) bitstream one bit per strobe, removes stuff bits, parses the frame fields, checks CRC-15 and framing, and presents the decoded message with a one-cycle valid pulse. It sits directly downstream of the stuffer's serial output, both in loopback self-test and behind the bus receiver/bit-sampler in the real link.

---
 rtl/can_frame_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_can_frame_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_decoder.sv
// CAN 2.0A receive-side frame decoder: destuffs the serial bitstream, parses the fields,
// checks CRC-15 and fixed-form bits, and pulses one status output per frame.
module can_frame_decoder #(
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        bit_i,
  input  logic        bit_valid_i,
  output logic [10:0] msg_id_o,
  output logic        rtr_o,
  output logic [3:0]  dlc_o,
  output logic [63:0] data_o,
  output logic        frame_valid_o,
  output logic        crc_error_o,
  output logic        stuff_error_o,
  output logic        form_error_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    StIdle, StArb, StCtrl, StData, StCrc, StCrcDel, StAck, StAckDel, StEof, StRecover
  } state_e;

  localparam logic [15:0] IdleBits = 16'(IDLE_BITS);

  state_e      state_q;
  logic [6:0]  cnt_q;
  logic [6:0]  len_q;
  logic        run_val_q;
  logic [2:0]  run_cnt_q;
  logic [14:0] crc_q;
  logic [14:0] crc_rx_q;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [15:0] rec_cnt_q;

  logic        stuff_region;
  logic        stuff_slot;
  logic        same_bit;
  logic [2:0]  run_cnt_inc;
  logic [14:0] crc_upd;
  logic [14:0] crc_rx_full;
  logic [3:0]  dlc_full;
  logic [6:0]  len_bits;

  always_comb begin
    stuff_region = (state_q == StArb) || (state_q == StCtrl) ||
                   (state_q == StData) || (state_q == StCrc);
    stuff_slot   = stuff_region && (run_cnt_q == 3'd5);
    same_bit     = (bit_i == run_val_q);
    run_cnt_inc  = same_bit ? 3'(run_cnt_q + 3'd1) : 3'd1;
    crc_upd      = {crc_q[13:0], 1'b0} ^ ({15{bit_i ^ crc_q[14]}} & 15'h4599);
    crc_rx_full  = {crc_rx_q[13:0], bit_i};
    dlc_full     = {dlc_q[2:0], bit_i};
    // DLC values 9..15 still carry only eight bytes.
    if (rtr_q)            len_bits = 7'd0;
    else if (dlc_full[3]) len_bits = 7'd64;
    else                  len_bits = {1'b0, dlc_full[2:0], 3'b000};
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      len_q         <= '0;
      run_val_q     <= 1'b0;
      run_cnt_q     <= '0;
      crc_q         <= '0;
      crc_rx_q      <= '0;
      id_q          <= '0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      data_q        <= '0;
      rec_cnt_q     <= '0;
      msg_id_o      <= '0;
      rtr_o         <= 1'b0;
      dlc_o         <= '0;
      data_o        <= '0;
      frame_valid_o <= 1'b0;
      crc_error_o   <= 1'b0;
      stuff_error_o <= 1'b0;
      form_error_o  <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      crc_error_o   <= 1'b0;
      stuff_error_o <= 1'b0;
      form_error_o  <= 1'b0;
      if (bit_valid_i) begin
        if (stuff_slot) begin
          if (same_bit) begin
            stuff_error_o <= 1'b1;
            rec_cnt_q     <= '0;
            state_q       <= StRecover;
          end else begin
            run_val_q <= bit_i;
            run_cnt_q <= 3'd1;
            // cnt_q parks at 15 when the final CRC bit still owes a stuff bit.
            if (state_q == StCrc && cnt_q == 7'd15) state_q <= StCrcDel;
          end
        end else begin
          if (stuff_region) begin
            run_val_q <= bit_i;
            run_cnt_q <= run_cnt_inc;
          end
          unique case (state_q)
            StIdle: begin
              if (!bit_i) begin
                state_q   <= StArb;
                cnt_q     <= '0;
                run_val_q <= 1'b0;
                run_cnt_q <= 3'd1;
                crc_q     <= '0;
                data_q    <= '0;
              end
            end
            StArb: begin
              crc_q <= crc_upd;
              if (cnt_q == 7'd11) begin
                rtr_q   <= bit_i;
                cnt_q   <= '0;
                state_q <= StCtrl;
              end else begin
                id_q  <= {id_q[9:0], bit_i};
                cnt_q <= cnt_q + 7'd1;
              end
            end
            StCtrl: begin
              crc_q <= crc_upd;
              if (cnt_q >= 7'd2) dlc_q <= dlc_full;
              if (cnt_q == 7'd0 && bit_i) begin
                form_error_o <= 1'b1;
                rec_cnt_q    <= '0;
                state_q      <= StRecover;
              end else if (cnt_q == 7'd5) begin
                len_q   <= len_bits;
                cnt_q   <= '0;
                state_q <= (len_bits == 7'd0) ? StCrc : StData;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
            StData: begin
              crc_q                        <= crc_upd;
              data_q[6'd63 - cnt_q[5:0]]   <= bit_i;
              if (cnt_q + 7'd1 == len_q) begin
                cnt_q   <= '0;
                state_q <= StCrc;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
            StCrc: begin
              crc_rx_q <= crc_rx_full;
              if (cnt_q == 7'd14) begin
                cnt_q <= 7'd15;
                if (crc_rx_full != crc_q) begin
                  crc_error_o <= 1'b1;
                  rec_cnt_q   <= '0;
                  state_q     <= StRecover;
                end else if (run_cnt_inc != 3'd5) begin
                  state_q <= StCrcDel;
                end
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
            StCrcDel, StAckDel: begin
              if (!bit_i) begin
                form_error_o <= 1'b1;
                rec_cnt_q    <= '0;
                state_q      <= StRecover;
              end else begin
                cnt_q   <= '0;
                state_q <= (state_q == StCrcDel) ? StAck : StEof;
              end
            end
            StAck: state_q <= StAckDel;
            StEof: begin
              if (!bit_i) begin
                form_error_o <= 1'b1;
                rec_cnt_q    <= '0;
                state_q      <= StRecover;
              end else if (cnt_q == 7'd6) begin
                msg_id_o      <= id_q;
                rtr_o         <= rtr_q;
                dlc_o         <= dlc_q;
                data_o        <= data_q;
                frame_valid_o <= 1'b1;
                state_q       <= StIdle;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
            StRecover: begin
              if (!bit_i) begin
                rec_cnt_q <= '0;
              end else if (rec_cnt_q + 16'd1 >= IdleBits) begin
                rec_cnt_q <= '0;
                state_q   <= StIdle;
              end else begin
                rec_cnt_q <= rec_cnt_q + 16'd1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_frame_decoder.sv
// Directed bench for can_frame_decoder: frames are built, CRC'd and stuffed here, then fed serially.
module tb_can_frame_decoder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        bit_i;
  logic        bit_valid_i;
  logic [10:0] msg_id_o;
  logic        rtr_o;
  logic [3:0]  dlc_o;
  logic [63:0] data_o;
  logic        frame_valid_o;
  logic        crc_error_o;
  logic        stuff_error_o;
  logic        form_error_o;
  logic        busy_o;

  can_frame_decoder #(.IDLE_BITS(11)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .msg_id_o     (msg_id_o),
    .rtr_o        (rtr_o),
    .dlc_o        (dlc_o),
    .data_o       (data_o),
    .frame_valid_o(frame_valid_o),
    .crc_error_o  (crc_error_o),
    .stuff_error_o(stuff_error_o),
    .form_error_o (form_error_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;
  int n_fv = 0, n_crc = 0, n_stuff = 0, n_form = 0, n_multi = 0;
  int s_fv, s_crc, s_stuff, s_form;
  bit frame_q[$];
  int last_crc;

  always @(negedge clock_i) begin
    if (frame_valid_o) n_fv <= n_fv + 1;
    if (crc_error_o) n_crc <= n_crc + 1;
    if (stuff_error_o) n_stuff <= n_stuff + 1;
    if (form_error_o) n_form <= n_form + 1;
    if (int'(frame_valid_o) + int'(crc_error_o) + int'(stuff_error_o) + int'(form_error_o) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #1;
    s_fv = n_fv; s_crc = n_crc; s_stuff = n_stuff; s_form = n_form;
  endtask

  task automatic check_counts(input string tag, input int fv, input int cr, input int st,
                              input int fo);
    #1;
    check({tag, "_fv"}, 64'(n_fv - s_fv), 64'(fv));
    check({tag, "_crc"}, 64'(n_crc - s_crc), 64'(cr));
    check({tag, "_stuff"}, 64'(n_stuff - s_stuff), 64'(st));
    check({tag, "_form"}, 64'(n_form - s_form), 64'(fo));
  endtask

  // Destuffed SOF..CRC, then stuffed, then the fixed tail; last_crc indexes the final CRC bit.
  task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] data, input int crc_flip, input int stuff_inv);
    bit raw[$];
    logic [14:0] c;
    int nbytes, run, nst;
    bit prev, b, s, nxt;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
    c = '0;
    foreach (raw[k]) begin
      nxt = raw[k] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(c[i] ^ (crc_flip == 14 - i));
    frame_q.delete();
    run = 0; nst = 0; prev = 1'b0;
    foreach (raw[k]) begin
      b = raw[k];
      frame_q.push_back(b);
      if (k == raw.size() - 1) last_crc = frame_q.size() - 1;
      if (k > 0 && b == prev) run++;
      else run = 1;
      prev = b;
      if (run == 5) begin
        s = ~b;
        if (nst == stuff_inv) s = b;
        nst++;
        frame_q.push_back(s);
        prev = s;
        run = 1;
      end
    end
    frame_q.push_back(1'b1);
    frame_q.push_back(1'b0);
    frame_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) frame_q.push_back(1'b1);
  endtask

  task automatic send(input int from, input int to, input bit gap);
    for (int i = from; i <= to; i++) begin
      @(negedge clock_i);
      bit_i = frame_q[i];
      bit_valid_i = 1'b1;
      if (gap) begin
        @(negedge clock_i);
        bit_valid_i = 1'b0;
      end
    end
    @(negedge clock_i);
    bit_valid_i = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_i);
      bit_i = 1'b1;
      bit_valid_i = 1'b1;
    end
    @(negedge clock_i);
    bit_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    bit_i = 1'b1;
    bit_valid_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_id", 64'(msg_id_o), 64'd0);
    check("rst_dlc", 64'(dlc_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_pulses", 64'({frame_valid_o, crc_error_o, stuff_error_o, form_error_o, rtr_o}),
          64'd0);
    reset_i = 1'b0;

    // Good loopback frame
    snap();
    build(11'h123, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1);
    send(0, frame_q.size() - 1, 1'b0);
    send_ones(12);
    check_counts("loop", 1, 0, 0, 0);
    check("loop_id", 64'(msg_id_o), 64'h123);
    check("loop_rtr", 64'(rtr_o), 64'd0);
    check("loop_dlc", 64'(dlc_o), 64'd4);
    check("loop_data", data_o, 64'hDEADBEEF_00000000);

    // CRC bit flipped before stuffing
    snap();
    build(11'h123, 1'b0, 4'd4, 64'hDEADBEEF_00000000, 3, -1);
    send(0, last_crc, 1'b0);
    check("crc_pulse", 64'(crc_error_o), 64'd1);
    @(negedge clock_i);
    check("crc_pulse_width", 64'(crc_error_o), 64'd0);
    send(last_crc + 1, frame_q.size() - 1, 1'b0);
    send_ones(12);
    check_counts("crc", 0, 1, 0, 0);
    check("crc_keep_data", data_o, 64'hDEADBEEF_00000000);
    check("crc_idle", 64'(busy_o), 64'd0);

    // Stuff-heavy all-zero frame with bit_valid_i toggling
    snap();
    build(11'h000, 1'b0, 4'd8, 64'd0, -1, -1);
    send(0, frame_q.size() - 1, 1'b1);
    send_ones(12);
    check_counts("heavy", 1, 0, 0, 0);
    check("heavy_id", 64'(msg_id_o), 64'd0);
    check("heavy_dlc", 64'(dlc_o), 64'd8);
    check("heavy_data", data_o, 64'd0);

    // First stuff bit inverted, then RECOVER needs 11 recessive bits
    snap();
    build(11'h000, 1'b0, 4'd8, 64'd0, -1, 0);
    send(0, 5, 1'b0);
    check("stuff_pulse", 64'(stuff_error_o), 64'd1);
    send_ones(5);
    send(0, 0, 1'b0);
    send_ones(10);
    check("recover_10", 64'(busy_o), 64'd1);
    send_ones(1);
    check("recover_11", 64'(busy_o), 64'd0);
    check_counts("stuff", 0, 0, 1, 0);

    // Form errors: CRC delimiter, ACK delimiter, EOF bit 4
    for (int f = 0; f < 3; f++) begin
      snap();
      build(11'h5A5, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1, -1);
      if (f == 0) frame_q[frame_q.size() - 10] = 1'b0;
      else if (f == 1) frame_q[frame_q.size() - 8] = 1'b0;
      else frame_q[frame_q.size() - 3] = 1'b0;
      send(0, frame_q.size() - 1, 1'b0);
      send_ones(12);
      check_counts($sformatf("form%0d", f), 0, 0, 0, 1);
      check($sformatf("form%0d_id", f), 64'(msg_id_o), 64'd0);
      check($sformatf("form%0d_dlc", f), 64'(dlc_o), 64'd8);
    end

    // RTR frame: no DATA even with DLC 8
    snap();
    build(11'h7FF, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
    send(0, frame_q.size() - 1, 1'b0);
    send_ones(12);
    check_counts("rtr", 1, 0, 0, 0);
    check("rtr_id", 64'(msg_id_o), 64'h7FF);
    check("rtr_rtr", 64'(rtr_o), 64'd1);
    check("rtr_dlc", 64'(dlc_o), 64'd8);
    check("rtr_data", data_o, 64'd0);

    // Reset in the middle of DATA, then a clean frame
    snap();
    build(11'h123, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1);
    send(0, 0, 1'b0);
    check("sof_busy", 64'(busy_o), 64'd1);
    send(1, 40, 1'b0);
    reset_i = 1'b1;
    @(negedge clock_i);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    reset_i = 1'b0;
    check_counts("mid_rst", 0, 0, 0, 0);
    snap();
    send(0, frame_q.size() - 1, 1'b0);
    send_ones(12);
    check_counts("after_rst", 1, 0, 0, 0);
    check("after_rst_id", 64'(msg_id_o), 64'h123);
    check("after_rst_data", data_o, 64'hDEADBEEF_00000000);

    #1;
    check("one_hot_pulses", 64'(n_multi), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
